// File: rtl/axi4_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : axi4_mem_arbiter
// Two-requester arbiter onto a single-outstanding AXI4 memory master port.
// Rev    : 1.0
// ============================================================================
module axi4_mem_arbiter #(
    parameter int PRIO_MODE   = 0,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wstrb,
    output logic [31:0] req_rdata,
    output logic        req_err,
    output logic        mem_axi_awvalid,
    input  logic        mem_axi_awready,
    output logic [31:0] mem_axi_awaddr,
    output logic [2:0]  mem_axi_awprot,
    output logic        mem_axi_wvalid,
    input  logic        mem_axi_wready,
    output logic [31:0] mem_axi_wdata,
    output logic [3:0]  mem_axi_wstrb,
    input  logic        mem_axi_bvalid,
    output logic        mem_axi_bready,
    output logic        mem_axi_arvalid,
    input  logic        mem_axi_arready,
    output logic [31:0] mem_axi_araddr,
    output logic [2:0]  mem_axi_arprot,
    input  logic        mem_axi_rvalid,
    output logic        mem_axi_rready,
    input  logic [31:0] mem_axi_rdata
);
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_ADDR = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    localparam int              c_CW    = $clog2(TIMEOUT_CYC + 2);
    localparam logic [c_CW-1:0] c_TO    = c_CW'(TIMEOUT_CYC);
    localparam logic            c_TO_EN = (TIMEOUT_CYC != 0);

    logic [1:0]      r_state;
    logic            r_gnt;
    logic            r_last;
    logic [31:0]     r_addr;
    logic [31:0]     r_wdata;
    logic [3:0]      r_wstrb;
    logic            r_awvalid;
    logic            r_wvalid;
    logic            r_arvalid;
    logic [c_CW-1:0] r_cnt;
    logic [31:0]     r_rdata;
    logic            r_err;

    logic            w_gnt;
    logic [31:0]     w_sel_addr;
    logic [31:0]     w_sel_wdata;
    logic [3:0]      w_sel_wstrb;
    logic            w_wr;
    logic            w_aw_ok;
    logic            w_w_ok;
    logic            w_resp;
    logic [c_CW-1:0] w_cnt_nxt;
    logic            w_expire;

    // On a tie, round-robin favours whoever was not served last.
    always_comb begin
        w_gnt = req_valid[1];
        if (req_valid == 2'b11) begin
            w_gnt = (PRIO_MODE == 1) ? 1'b0 : ~r_last;
        end
    end

    assign w_sel_addr  = w_gnt ? req_addr[63:32]  : req_addr[31:0];
    assign w_sel_wdata = w_gnt ? req_wdata[63:32] : req_wdata[31:0];
    assign w_sel_wstrb = w_gnt ? req_wstrb[7:4]   : req_wstrb[3:0];

    assign w_wr      = |r_wstrb;
    assign w_aw_ok   = ~r_awvalid | mem_axi_awready;
    assign w_w_ok    = ~r_wvalid | mem_axi_wready;
    assign w_resp    = w_wr ? mem_axi_bvalid : mem_axi_rvalid;
    assign w_cnt_nxt = r_cnt + c_CW'(1);
    assign w_expire  = c_TO_EN && (w_cnt_nxt == c_TO);

    always_ff @(posedge hclk) begin
        if (hreset) begin
            r_state   <= c_IDLE;
            r_gnt     <= 1'b0;
            r_last    <= 1'b1;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_arvalid <= 1'b0;
            r_cnt     <= '0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (|req_valid) begin
                        r_gnt     <= w_gnt;
                        r_addr    <= w_sel_addr;
                        r_wdata   <= w_sel_wdata;
                        r_wstrb   <= w_sel_wstrb;
                        r_awvalid <= |w_sel_wstrb;
                        r_wvalid  <= |w_sel_wstrb;
                        r_arvalid <= ~|w_sel_wstrb;
                        r_state   <= c_ADDR;
                    end
                end
                c_ADDR: begin
                    if (w_wr) begin
                        if (mem_axi_awready) r_awvalid <= 1'b0;
                        if (mem_axi_wready)  r_wvalid  <= 1'b0;
                        if (w_aw_ok && w_w_ok) begin
                            r_cnt   <= '0;
                            r_state <= c_RESP;
                        end
                    end else if (mem_axi_arready) begin
                        r_arvalid <= 1'b0;
                        r_cnt     <= '0;
                        r_state   <= c_RESP;
                    end
                end
                c_RESP: begin
                    // A response on the expiry cycle wins over the abort.
                    if (w_resp) begin
                        r_rdata <= w_wr ? 32'h0 : mem_axi_rdata;
                        r_err   <= 1'b0;
                        r_state <= c_DONE;
                    end else if (w_expire) begin
                        r_rdata <= 32'hDEADBEEF;
                        r_err   <= 1'b1;
                        r_state <= c_DONE;
                    end else begin
                        r_cnt <= w_cnt_nxt;
                    end
                end
                default: begin
                    r_last  <= r_gnt;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign req_ready       = (r_state == c_DONE) ? (r_gnt ? 2'b10 : 2'b01) : 2'b00;
    assign req_rdata       = (r_state == c_DONE) ? r_rdata : 32'h0;
    assign req_err         = (r_state == c_DONE) & r_err;
    assign mem_axi_awvalid = r_awvalid;
    assign mem_axi_wvalid  = r_wvalid;
    assign mem_axi_arvalid = r_arvalid;
    assign mem_axi_awaddr  = r_addr;
    assign mem_axi_araddr  = r_addr;
    assign mem_axi_wdata   = r_wdata;
    assign mem_axi_wstrb   = r_wstrb;
    assign mem_axi_bready  = (r_state == c_RESP) & w_wr;
    assign mem_axi_rready  = (r_state == c_RESP) & ~w_wr;
    assign mem_axi_awprot  = 3'b000;
    assign mem_axi_arprot  = 3'b000;

endmodule
`default_nettype wire

// File: tb/tb_axi4_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_axi4_mem_arbiter
// Self-checking bench: vector table, randomized transactions, corner sequences.
// Rev    : 1.0
// ============================================================================
module tb_axi4_mem_arbiter;
    localparam int TO = 8;

    logic        hclk = 1'b0;
    logic        hreset = 1'b1;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [7:0]  req_wstrb = '0;
    logic [31:0] req_rdata;
    logic        req_err;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [3:0]  wstrb;
    logic [2:0]  awprot, arprot;

    int          aw_dly = 0, w_dly = 0, ar_dly = 0, rsp_dly = 0;
    bit          rsp_never = 1'b0;
    logic [31:0] s_rdata = '0;
    int          aw_wait = 0, w_wait = 0, ar_wait = 0, rsp_wait = 0;
    int          aw_hi = 0, w_hi = 0;
    logic [31:0] cap_awaddr = '0, cap_araddr = '0, cap_wdata = '0;
    logic [3:0]  cap_wstrb = '0;

    int n_chk = 0;
    int n_fail = 0;

    always #5 hclk = ~hclk;

    axi4_mem_arbiter #(.PRIO_MODE(0), .TIMEOUT_CYC(TO)) u_dut (
        .hclk(hclk), .hreset(hreset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .req_rdata(req_rdata), .req_err(req_err),
        .mem_axi_awvalid(awvalid), .mem_axi_awready(awready),
        .mem_axi_awaddr(awaddr), .mem_axi_awprot(awprot),
        .mem_axi_wvalid(wvalid), .mem_axi_wready(wready),
        .mem_axi_wdata(wdata), .mem_axi_wstrb(wstrb),
        .mem_axi_bvalid(bvalid), .mem_axi_bready(bready),
        .mem_axi_arvalid(arvalid), .mem_axi_arready(arready),
        .mem_axi_araddr(araddr), .mem_axi_arprot(arprot),
        .mem_axi_rvalid(rvalid), .mem_axi_rready(rready),
        .mem_axi_rdata(rdata)
    );

    // Slave with programmable wait states
    assign awready = awvalid && (aw_wait >= aw_dly);
    assign wready  = wvalid && (w_wait >= w_dly);
    assign arready = arvalid && (ar_wait >= ar_dly);
    assign bvalid  = bready && !rsp_never && (rsp_wait >= rsp_dly);
    assign rvalid  = rready && !rsp_never && (rsp_wait >= rsp_dly);
    assign rdata   = s_rdata;

    always @(posedge hclk) begin
        if (hreset) begin
            aw_wait <= 0; w_wait <= 0; ar_wait <= 0; rsp_wait <= 0;
        end else begin
            aw_wait  <= (awvalid && !awready) ? aw_wait + 1 : 0;
            w_wait   <= (wvalid && !wready) ? w_wait + 1 : 0;
            ar_wait  <= (arvalid && !arready) ? ar_wait + 1 : 0;
            rsp_wait <= ((bready || rready) && !(bvalid || rvalid)) ? rsp_wait + 1 : 0;
            if (awvalid) aw_hi <= aw_hi + 1;
            if (wvalid)  w_hi  <= w_hi + 1;
            if (awvalid && awready) cap_awaddr <= awaddr;
            if (arvalid && arready) cap_araddr <= araddr;
            if (wvalid && wready) begin
                cap_wdata <= wdata;
                cap_wstrb <= wstrb;
            end
        end
    end

    // Fixed-priority instance with an always-ready slave and both requesters busy
    logic [1:0]  fp_req_ready;
    logic [31:0] fp_req_rdata, fp_awaddr, fp_araddr, fp_wdata;
    logic        fp_req_err, fp_awvalid, fp_wvalid, fp_bready, fp_arvalid, fp_rready;
    logic [3:0]  fp_wstrb;
    logic [2:0]  fp_awprot, fp_arprot;
    int          fp_g0 = 0, fp_g1 = 0;

    axi4_mem_arbiter #(.PRIO_MODE(1), .TIMEOUT_CYC(TO)) u_dut_fp (
        .hclk(hclk), .hreset(hreset),
        .req_valid(2'b11), .req_ready(fp_req_ready),
        .req_addr(64'h0000_2000_0000_1000), .req_wdata(64'h0), .req_wstrb(8'h00),
        .req_rdata(fp_req_rdata), .req_err(fp_req_err),
        .mem_axi_awvalid(fp_awvalid), .mem_axi_awready(1'b1),
        .mem_axi_awaddr(fp_awaddr), .mem_axi_awprot(fp_awprot),
        .mem_axi_wvalid(fp_wvalid), .mem_axi_wready(1'b1),
        .mem_axi_wdata(fp_wdata), .mem_axi_wstrb(fp_wstrb),
        .mem_axi_bvalid(fp_bready), .mem_axi_bready(fp_bready),
        .mem_axi_arvalid(fp_arvalid), .mem_axi_arready(1'b1),
        .mem_axi_araddr(fp_araddr), .mem_axi_arprot(fp_arprot),
        .mem_axi_rvalid(fp_rready), .mem_axi_rready(fp_rready),
        .mem_axi_rdata(32'h5555_AAAA)
    );

    always @(negedge hclk) begin
        if (fp_req_ready[0]) fp_g0 <= fp_g0 + 1;
        if (fp_req_ready[1]) fp_g1 <= fp_g1 + 1;
    end

    typedef struct {
        int          idx;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] sdata;
        int          awd;
        int          wd;
        int          ard;
        int          rd;
        bit          never;
        int          exp_cyc;
        logic [31:0] exp_rd;
        bit          exp_err;
        int          exp_aw;
        int          exp_w;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    // Reference: address phase ends when the slowest channel accepts, the
    // response phase lasts until the response or TO cycles, then one DONE cycle.
    function automatic vec_t model(input vec_t v);
        vec_t o;
        int   a, r;
        bit   wr;
        o  = v;
        wr = (v.wstrb != 4'h0);
        a  = wr ? ((v.awd > v.wd ? v.awd : v.wd) + 1) : (v.ard + 1);
        if (!v.never && (v.rd + 1 <= TO)) begin
            r = v.rd + 1;
            o.exp_rd  = wr ? 32'h0 : v.sdata;
            o.exp_err = 1'b0;
        end else begin
            r = TO;
            o.exp_rd  = 32'hDEADBEEF;
            o.exp_err = 1'b1;
        end
        o.exp_cyc = a + r + 2;
        o.exp_aw  = wr ? v.awd + 1 : 0;
        o.exp_w   = wr ? v.wd + 1 : 0;
        return o;
    endfunction

    task automatic do_reset();
        hreset    = 1'b1;
        req_valid = 2'b00;
        repeat (2) @(posedge hclk);
        #1;
        chk("reset_outputs", {req_ready, req_err, req_rdata, awvalid, wvalid, arvalid, bready, rready}, 64'h0);
        hreset = 1'b0;
        @(posedge hclk);
        #1;
    endtask

    // Called one time unit after a rising edge with the DUT idle.
    task automatic run_txn(input vec_t v, input bit scramble);
        int got;
        int aw0, w0;
        aw_dly = v.awd; w_dly = v.wd; ar_dly = v.ard; rsp_dly = v.rd;
        rsp_never = v.never; s_rdata = v.sdata;
        req_addr  = {$urandom, $urandom};
        req_wdata = {$urandom, $urandom};
        req_wstrb = 8'($urandom);
        if (v.idx == 0) begin
            req_addr[31:0] = v.addr; req_wdata[31:0] = v.wdata; req_wstrb[3:0] = v.wstrb;
        end else begin
            req_addr[63:32] = v.addr; req_wdata[63:32] = v.wdata; req_wstrb[7:4] = v.wstrb;
        end
        req_valid = (v.idx == 0) ? 2'b01 : 2'b10;
        aw0 = aw_hi;
        w0  = w_hi;
        got = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge hclk);
            if (req_ready != 2'b00) begin
                got = c;
                break;
            end
            @(posedge hclk);
            #1;
            if (scramble) begin
                req_addr  = {$urandom, $urandom};
                req_wdata = {$urandom, $urandom};
            end
        end
        if (got == 0) begin
            chk("ready_timeout", 64'(got), 64'(v.exp_cyc));
            do_reset();
        end else begin
            chk("latency", 64'(got), 64'(v.exp_cyc));
            chk("ready_index", {62'h0, req_ready}, (v.idx == 0) ? 64'h1 : 64'h2);
            chk("rdata", {32'h0, req_rdata}, {32'h0, v.exp_rd});
            chk("err", {63'h0, req_err}, {63'h0, v.exp_err});
            chk("axi_idle_in_done", {59'h0, awvalid, wvalid, arvalid, bready, rready}, 64'h0);
            chk("aw_valid_cycles", 64'(aw_hi - aw0), 64'(v.exp_aw));
            chk("w_valid_cycles", 64'(w_hi - w0), 64'(v.exp_w));
            if (v.wstrb != 4'h0) begin
                chk("awaddr", {32'h0, cap_awaddr}, {32'h0, v.addr});
                chk("wdata", {32'h0, cap_wdata}, {32'h0, v.wdata});
                chk("wstrb", {60'h0, cap_wstrb}, {60'h0, v.wstrb});
            end else begin
                chk("araddr", {32'h0, cap_araddr}, {32'h0, v.addr});
            end
            @(posedge hclk);
            #1;
            req_valid = 2'b00;
            @(negedge hclk);
            chk("single_pulse", {62'h0, req_ready}, 64'h0);
            @(posedge hclk);
            #1;
        end
    endtask

    vec_t vt[7];
    vec_t rv;

    initial begin
        int g, got, pulses;
        vt[0] = '{0, 32'h100, 32'h0,        4'h0, 32'hCAFEF00D, 0, 0, 0, 0, 1'b0, 4,  32'hCAFEF00D, 1'b0, 0, 0};
        vt[1] = '{1, 32'h200, 32'h12345678, 4'hF, 32'h0,        3, 0, 0, 0, 1'b0, 7,  32'h0,        1'b0, 4, 1};
        vt[2] = '{1, 32'h300, 32'h0,        4'h0, 32'hA5A50001, 0, 0, 2, 3, 1'b0, 9,  32'hA5A50001, 1'b0, 0, 0};
        vt[3] = '{0, 32'h400, 32'h0,        4'h0, 32'h11111111, 0, 0, 0, 0, 1'b1, 11, 32'hDEADBEEF, 1'b1, 0, 0};
        vt[4] = '{0, 32'h500, 32'h0,        4'h0, 32'h0BADCAFE, 0, 0, 0, 7, 1'b0, 11, 32'h0BADCAFE, 1'b0, 0, 0};
        vt[5] = '{0, 32'h600, 32'hDEAD0005, 4'h3, 32'h77,       0, 2, 0, 1, 1'b0, 7,  32'h0,        1'b0, 1, 3};
        vt[6] = '{1, 32'h700, 32'h0F0F0F0F, 4'h8, 32'h0,        1, 1, 0, 0, 1'b1, 12, 32'hDEADBEEF, 1'b1, 2, 2};

        do_reset();
        chk("prot_zero", {58'h0, awprot, arprot}, 64'h0);

        for (int i = 0; i < 7; i++) run_txn(vt[i], 1'b0);

        for (int i = 0; i < 30; i++) begin
            rv.idx   = int'($urandom_range(1, 0));
            rv.addr  = $urandom;
            rv.wdata = $urandom;
            rv.wstrb = ($urandom_range(1, 0) == 1) ? 4'($urandom_range(15, 1)) : 4'h0;
            rv.sdata = $urandom;
            rv.awd   = int'($urandom_range(3, 0));
            rv.wd    = int'($urandom_range(3, 0));
            rv.ard   = int'($urandom_range(3, 0));
            rv.rd    = int'($urandom_range(9, 0));
            rv.never = ($urandom_range(9, 0) == 0);
            run_txn(model(rv), 1'b1);
        end

        // Round-robin with both requesters held valid
        do_reset();
        aw_dly = 0; w_dly = 0; ar_dly = 0; rsp_dly = 0; rsp_never = 1'b0;
        req_wstrb = 8'h00;
        req_addr  = {32'h2000, 32'h1000};
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            g = -1;
            for (int c = 0; c < 20; c++) begin
                @(negedge hclk);
                if (req_ready != 2'b00) begin
                    g = req_ready[1] ? 1 : 0;
                    break;
                end
            end
            chk($sformatf("rr_grant%0d", k), 64'(g), 64'(k % 2));
            chk($sformatf("rr_addr%0d", k), {32'h0, cap_araddr}, (k % 2 == 1) ? 64'h2000 : 64'h1000);
            @(posedge hclk);
            #1;
        end
        req_valid = 2'b00;
        repeat (3) @(posedge hclk);
        #1;

        // Reset while waiting in the response phase
        rsp_never = 1'b1;
        req_addr  = 64'h0000_0000_0000_0800;
        req_valid = 2'b01;
        got = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge hclk);
            if (rready) begin
                got = 1;
                break;
            end
        end
        chk("rst_reach_resp", 64'(got), 64'h1);
        @(posedge hclk);
        #1;
        hreset    = 1'b1;
        req_valid = 2'b00;
        @(posedge hclk);
        @(negedge hclk);
        chk("rst_mid_outputs", {req_ready, req_err, req_rdata, awvalid, wvalid, arvalid, bready, rready}, 64'h0);
        @(posedge hclk);
        #1;
        hreset    = 1'b0;
        rsp_never = 1'b0;
        pulses = 0;
        repeat (12) begin
            @(negedge hclk);
            if (req_ready != 2'b00) pulses++;
        end
        chk("rst_no_ready", 64'(pulses), 64'h0);
        @(posedge hclk);
        #1;
        run_txn(vt[0], 1'b0);

        chk("fp_grants_req1", 64'(fp_g1), 64'h0);
        chk("fp_grants_req0_seen", {63'h0, (fp_g0 != 0)}, 64'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
